// File: rtl/touch_pulse_out.sv
// touch_pulse_out: Avalon-MM output PIO that drives a timed pulse plus recovery gap on out_port.
// Define PULSE_RPT_EN to enable repeated pulse/gap pairs (start bits[15:8]); that build needs WIDTH_W >= 16.
module touch_pulse_out #(
  parameter int WIDTH_W    = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [WIDTH_W-1:0] writedata,
  output logic [WIDTH_W-1:0] readdata,
  output logic               out_port,
  output logic               irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH_W-1:0] r_width, w_width_m1;
  logic [WIDTH_W-1:0] r_readdata, w_rd;
  logic               r_level, r_mask, r_done, r_active;
  logic               w_done_nxt, w_done_set, w_done_clr_start;
  logic               w_wr, w_start, w_abort, w_clr, w_busy;

`ifdef PULSE_RPT_EN
  logic [7:0]         r_rpt, w_rpt_nxt;
  logic [WIDTH_W-1:0] r_wlen_m1, w_wlen_nxt;
`endif

  assign w_wr       = chipselect & ~write_n;
  assign w_start    = w_wr && (address == 2'd3) && writedata[0];
  assign w_abort    = w_wr && (address == 2'd3) && writedata[1];
  assign w_clr      = w_wr && (address == 2'd3) && writedata[2];
  assign w_busy     = (r_state != S_IDLE);
  assign w_width_m1 = (r_width == '0) ? '0 : r_width - WIDTH_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_done_set       = 1'b0;
    w_done_clr_start = 1'b0;
`ifdef PULSE_RPT_EN
    w_rpt_nxt        = r_rpt;
    w_wlen_nxt       = r_wlen_m1;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt      = S_PULSE;
          w_cnt_nxt        = w_width_m1;
          w_done_clr_start = 1'b1;
`ifdef PULSE_RPT_EN
          w_rpt_nxt        = writedata[15:8];
          w_wlen_nxt       = w_width_m1;
`endif
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = WIDTH_W'(GAP_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - WIDTH_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WIDTH_W'(1);
        end
`ifdef PULSE_RPT_EN
        // Repeats reuse the width latched at start, not the live register.
        else if (r_rpt != 8'd0) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = r_wlen_m1;
          w_rpt_nxt   = r_rpt - 8'd1;
        end
`endif
        else begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides everything, including a start in the same write.
    if (w_abort) begin
      w_state_nxt      = S_IDLE;
      w_cnt_nxt        = '0;
      w_done_set       = 1'b0;
      w_done_clr_start = 1'b0;
`ifdef PULSE_RPT_EN
      w_rpt_nxt        = 8'd0;
`endif
    end

    w_done_nxt = w_done_set | (r_done & ~w_clr & ~w_done_clr_start);
  end

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0: w_rd[0] = r_level;
      2'd1: w_rd    = r_width;
      2'd2: w_rd[0] = r_mask;
      default: begin
        w_rd[0] = w_busy;
        w_rd[1] = r_done;
`ifdef PULSE_RPT_EN
        w_rd[15:8] = r_rpt;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_active   <= 1'b0;
      r_level    <= 1'b0;
      r_width    <= '0;
      r_mask     <= 1'b0;
      r_readdata <= '0;
`ifdef PULSE_RPT_EN
      r_rpt      <= 8'd0;
      r_wlen_m1  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_active   <= (w_state_nxt == S_PULSE);
      r_readdata <= w_rd;
`ifdef PULSE_RPT_EN
      r_rpt      <= w_rpt_nxt;
      r_wlen_m1  <= w_wlen_nxt;
`endif
      if (w_wr) begin
        case (address)
          2'd0:    r_level <= writedata[0];
          2'd1:    r_width <= writedata;
          2'd2:    r_mask  <= writedata[0];
          default: ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_level ^ r_active;
  assign irq      = r_done & r_mask;

endmodule
